// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: counter encodings, default index width, PC helper.
package bp_pkg;
  localparam int DEF_IDX_W = 6;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor; slave is the predictor, master drives requests.
interface branch_predictor_if;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_stall;
  logic        pred_resp_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output pred_valid, pred_pc, pred_stall,
    output upd_valid, upd_pc, upd_target, upd_taken, upd_pred_taken, upd_pred_target,
    input  pred_resp_valid, pred_taken, pred_target,
    input  redirect_valid, redirect_pc, stat_branches, stat_mispredicts
  );

  modport slave (
    input  pred_valid, pred_pc, pred_stall,
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_pred_taken, upd_pred_target,
    output pred_resp_valid, pred_taken, pred_target,
    output redirect_valid, redirect_pc, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state; purely combinational, no backpressure.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; predictions and redirects appear 1 cycle after the request.
// pred_stall freezes the prediction outputs and suppresses the table read; updates are never stalled.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input logic               clk,
  input logic               resetn,
  branch_predictor_if.slave bp
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [1:0]       cnt_q    [DEPTH];

  logic [IDX_W-1:0] p_idx, u_idx;
  logic [TAG_W-1:0] p_tag, u_tag;
  logic             p_hit, p_taken;
  logic             u_hit, mispredict;
  logic [1:0]       u_cnt_next;

  assign p_idx   = bp.pred_pc[IDX_W+1:2];
  assign p_tag   = bp.pred_pc[31:IDX_W+2];
  assign p_hit   = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
  assign p_taken = p_hit && cnt_q[p_idx][1];

  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign mispredict = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

  bp_sat_counter u_sat (
    .cnt      (cnt_q[u_idx]),
    .taken    (bp.upd_taken),
    .cnt_next (u_cnt_next)
  );

  // Prediction register: reads the table before this edge's update lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bp.pred_resp_valid <= 1'b0;
      bp.pred_taken      <= 1'b0;
      bp.pred_target     <= 32'd0;
    end else if (!bp.pred_stall) begin
      bp.pred_resp_valid <= bp.pred_valid;
      if (bp.pred_valid) begin
        bp.pred_taken  <= p_taken;
        bp.pred_target <= p_taken ? target_q[p_idx] : pc_plus4(bp.pred_pc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (bp.upd_valid && !u_hit && bp.upd_taken) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // Tag/target/counter carry no reset; allocation fully re-initialises an entry.
  always_ff @(posedge clk) begin
    if (resetn && bp.upd_valid) begin
      if (u_hit) begin
        cnt_q[u_idx] <= u_cnt_next;
        if (bp.upd_taken) target_q[u_idx] <= bp.upd_target;
      end else if (bp.upd_taken) begin
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bp.upd_target;
        cnt_q[u_idx]    <= CNT_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bp.redirect_valid <= 1'b0;
      bp.redirect_pc    <= 32'd0;
    end else begin
      bp.redirect_valid <= mispredict;
      if (mispredict) bp.redirect_pc <= bp.upd_taken ? bp.upd_target : pc_plus4(bp.upd_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bp.stat_branches    <= 32'd0;
      bp.stat_mispredicts <= 32'd0;
    end else begin
      if (bp.upd_valid && (bp.stat_branches != 32'hFFFF_FFFF))
        bp.stat_branches <= bp.stat_branches + 32'd1;
      if (mispredict && (bp.stat_mispredicts != 32'hFFFF_FFFF))
        bp.stat_mispredicts <= bp.stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic against an array-based model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic resetn;
  int   chk = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  branch_predictor_if bpi ();

  branch_predictor #(.IDX_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bp     (bpi)
  );

  // Reference model: plain arrays, counter held as an integer 0..3.
  bit          mv   [64];
  logic [23:0] mtag [64];
  logic [31:0] mtgt [64];
  int          mcnt [64];
  logic        e_rv, e_tk, e_redv;
  logic [31:0] e_tgt, e_rpc, e_br, e_mp;

  task automatic model_edge();
    int i;
    bit hit, tk, mp;
    if (!resetn) begin
      for (int k = 0; k < 64; k++) mv[k] = 0;
      e_rv = 0; e_tk = 0; e_tgt = 0; e_redv = 0; e_rpc = 0; e_br = 0; e_mp = 0;
      return;
    end
    if (!bpi.pred_stall) begin
      e_rv = bpi.pred_valid;
      if (bpi.pred_valid) begin
        i   = (bpi.pred_pc >> 2) % 64;
        hit = mv[i] && (mtag[i] == bpi.pred_pc[31:8]);
        tk  = hit && (mcnt[i] >= 2);
        e_tk  = tk;
        e_tgt = tk ? mtgt[i] : bpi.pred_pc + 32'd4;
      end
    end
    mp = bpi.upd_valid && ((bpi.upd_taken != bpi.upd_pred_taken) ||
                           (bpi.upd_taken && bpi.upd_target != bpi.upd_pred_target));
    e_redv = mp;
    if (mp) e_rpc = bpi.upd_taken ? bpi.upd_target : bpi.upd_pc + 32'd4;
    if (bpi.upd_valid) begin
      if (e_br != 32'hFFFF_FFFF) e_br = e_br + 1;
      if (mp && e_mp != 32'hFFFF_FFFF) e_mp = e_mp + 1;
      i   = (bpi.upd_pc >> 2) % 64;
      hit = mv[i] && (mtag[i] == bpi.upd_pc[31:8]);
      if (hit) begin
        mcnt[i] = bpi.upd_taken ? ((mcnt[i] < 3) ? mcnt[i] + 1 : 3) : ((mcnt[i] > 0) ? mcnt[i] - 1 : 0);
        if (bpi.upd_taken) mtgt[i] = bpi.upd_target;
      end else if (bpi.upd_taken) begin
        mv[i] = 1; mtag[i] = bpi.upd_pc[31:8]; mtgt[i] = bpi.upd_target; mcnt[i] = 2;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    resetn = 1'b1;
    bpi.pred_valid = 0; bpi.pred_pc = 0; bpi.pred_stall = 0;
    bpi.upd_valid = 0; bpi.upd_pc = 0; bpi.upd_target = 0;
    bpi.upd_taken = 0; bpi.upd_pred_taken = 0; bpi.upd_pred_target = 0;
  endtask

  task automatic predict(input logic [31:0] pc);
    bpi.pred_valid = 1; bpi.pred_pc = pc;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    bpi.upd_valid = 1; bpi.upd_pc = pc; bpi.upd_taken = tk; bpi.upd_target = tgt;
    bpi.upd_pred_taken = ptk; bpi.upd_pred_target = ptgt;
  endtask

  task automatic test_reset();
    idle(); resetn = 0; predict(32'h1C00_0000); update(32'h1C00_0010, 1, 32'h1C00_0100, 0, 0);
    step();
    chk++; if (bpi.pred_resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid: got %0h want 0", bpi.pred_resp_valid); end
    chk++; if (bpi.pred_taken !== 1'b0) begin errs++; $display("FAIL reset_taken: got %0h want 0", bpi.pred_taken); end
    chk++; if (bpi.pred_target !== 32'd0) begin errs++; $display("FAIL reset_target: got %08h want 0", bpi.pred_target); end
    chk++; if (bpi.redirect_valid !== 1'b0 || bpi.redirect_pc !== 32'd0) begin errs++; $display("FAIL reset_redirect: got %0h/%08h want 0/0", bpi.redirect_valid, bpi.redirect_pc); end
    chk++; if (bpi.stat_branches !== 32'd0 || bpi.stat_mispredicts !== 32'd0) begin errs++; $display("FAIL reset_stats: got %0d/%0d want 0/0", bpi.stat_branches, bpi.stat_mispredicts); end
  endtask

  task automatic test_basic();
    idle(); predict(32'h1C00_0000); step();
    chk++; if ({bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target} !== {2'b10, 32'h1C00_0004}) begin errs++; $display("FAIL basic_miss_pred: got %0h/%0h/%08h want 1/0/1c000004", bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target); end
    idle(); update(32'h1C00_0010, 1, 32'h1C00_0100, 0, 32'h1C00_0014); step();
    chk++; if ({bpi.redirect_valid, bpi.redirect_pc} !== {1'b1, 32'h1C00_0100}) begin errs++; $display("FAIL basic_redirect: got %0h/%08h want 1/1c000100", bpi.redirect_valid, bpi.redirect_pc); end
    idle(); step();
    chk++; if (bpi.redirect_valid !== 1'b0) begin errs++; $display("FAIL basic_redirect_pulse: got %0h want 0", bpi.redirect_valid); end
    chk++; if (bpi.pred_resp_valid !== 1'b0) begin errs++; $display("FAIL basic_resp_clear: got %0h want 0", bpi.pred_resp_valid); end
    predict(32'h1C00_0010); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b1, 32'h1C00_0100}) begin errs++; $display("FAIL basic_hit_pred: got %0h/%08h want 1/1c000100", bpi.pred_taken, bpi.pred_target); end
  endtask

  task automatic test_not_taken();
    idle(); update(32'h1C00_0010, 0, 32'h1C00_0100, 1, 32'h1C00_0100); step();
    chk++; if ({bpi.redirect_valid, bpi.redirect_pc} !== {1'b1, 32'h1C00_0014}) begin errs++; $display("FAIL nt_redirect: got %0h/%08h want 1/1c000014", bpi.redirect_valid, bpi.redirect_pc); end
    update(32'h1C00_0010, 0, 32'h1C00_0100, 0, 32'h1C00_0014); step();
    chk++; if (bpi.redirect_valid !== 1'b0) begin errs++; $display("FAIL nt_no_redirect: got %0h want 0", bpi.redirect_valid); end
    step();
    chk++; if ({bpi.stat_branches, bpi.stat_mispredicts} !== {32'd4, 32'd2}) begin errs++; $display("FAIL nt_stats: got %0d/%0d want 4/2", bpi.stat_branches, bpi.stat_mispredicts); end
    idle(); predict(32'h1C00_0010); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b0, 32'h1C00_0014}) begin errs++; $display("FAIL nt_pred: got %0h/%08h want 0/1c000014", bpi.pred_taken, bpi.pred_target); end
    // A single taken outcome from a saturated-low counter must stay below the taken threshold.
    idle(); update(32'h1C00_0010, 1, 32'h1C00_0100, 0, 32'h1C00_0014); step();
    idle(); predict(32'h1C00_0010); step();
    chk++; if (bpi.pred_taken !== 1'b0) begin errs++; $display("FAIL nt_saturated_low: got %0h want 0", bpi.pred_taken); end
  endtask

  task automatic test_same_cycle();
    idle(); predict(32'h1C00_0010); update(32'h1C00_0010, 1, 32'h1C00_0100, 0, 32'h1C00_0014); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b0, 32'h1C00_0014}) begin errs++; $display("FAIL same_cycle_old: got %0h/%08h want 0/1c000014", bpi.pred_taken, bpi.pred_target); end
    idle(); predict(32'h1C00_0010); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b1, 32'h1C00_0100}) begin errs++; $display("FAIL same_cycle_new: got %0h/%08h want 1/1c000100", bpi.pred_taken, bpi.pred_target); end
  endtask

  task automatic test_alias();
    idle(); update(32'h1C00_0110, 1, 32'h1C00_0200, 0, 32'h1C00_0114); step();
    idle(); predict(32'h1C00_0010); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b0, 32'h1C00_0014}) begin errs++; $display("FAIL alias_evicted: got %0h/%08h want 0/1c000014", bpi.pred_taken, bpi.pred_target); end
    predict(32'h1C00_0110); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b1, 32'h1C00_0200}) begin errs++; $display("FAIL alias_new: got %0h/%08h want 1/1c000200", bpi.pred_taken, bpi.pred_target); end
    chk++; if ({bpi.stat_branches, bpi.stat_mispredicts} !== {32'd7, 32'd5}) begin errs++; $display("FAIL alias_stats: got %0d/%0d want 7/5", bpi.stat_branches, bpi.stat_mispredicts); end
  endtask

  task automatic test_stall();
    idle(); predict(32'h1C00_0110); step();
    bpi.pred_stall = 1; predict(32'h1C00_0000); step(); step();
    chk++; if ({bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target} !== {2'b11, 32'h1C00_0200}) begin errs++; $display("FAIL stall_hold: got %0h/%0h/%08h want 1/1/1c000200", bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target); end
    idle(); step();
    chk++; if (bpi.pred_resp_valid !== 1'b0) begin errs++; $display("FAIL stall_release_clear: got %0h want 0", bpi.pred_resp_valid); end
  endtask

  task automatic test_wrap();
    idle(); predict(32'hFFFF_FFFC); update(32'hFFFF_FFFC, 0, 32'h0000_1000, 1, 32'h0000_1000); step();
    chk++; if (bpi.pred_target !== 32'd0) begin errs++; $display("FAIL wrap_pred_target: got %08h want 0", bpi.pred_target); end
    chk++; if ({bpi.redirect_valid, bpi.redirect_pc} !== {1'b1, 32'd0}) begin errs++; $display("FAIL wrap_redirect: got %0h/%08h want 1/0", bpi.redirect_valid, bpi.redirect_pc); end
  endtask

  task automatic test_reset_midop();
    idle(); update(32'h1C00_0040, 1, 32'h1C00_0300, 0, 32'h1C00_0044); step();
    resetn = 0; bpi.pred_stall = 1; predict(32'h1C00_0110);
    update(32'h1C00_0080, 1, 32'h1C00_0400, 0, 32'h1C00_0084); step();
    chk++; if ({bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target, bpi.redirect_valid, bpi.redirect_pc} !== 67'd0) begin errs++; $display("FAIL midop_outputs: got %0h/%0h/%08h/%0h/%08h want all 0", bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target, bpi.redirect_valid, bpi.redirect_pc); end
    chk++; if ({bpi.stat_branches, bpi.stat_mispredicts} !== 64'd0) begin errs++; $display("FAIL midop_stats: got %0d/%0d want 0/0", bpi.stat_branches, bpi.stat_mispredicts); end
    foreach (mv[k]) begin end
    idle(); predict(32'h1C00_0040); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b0, 32'h1C00_0044}) begin errs++; $display("FAIL midop_miss_a: got %0h/%08h want 0/1c000044", bpi.pred_taken, bpi.pred_target); end
    predict(32'h1C00_0110); step();
    chk++; if ({bpi.pred_taken, bpi.pred_target} !== {1'b0, 32'h1C00_0114}) begin errs++; $display("FAIL midop_miss_b: got %0h/%08h want 0/1c000114", bpi.pred_taken, bpi.pred_target); end
    predict(32'h1C00_0080); step();
    chk++; if (bpi.pred_taken !== 1'b0) begin errs++; $display("FAIL midop_discarded_upd: got %0h want 0", bpi.pred_taken); end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return 32'h1C00_0000 | ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 8);
  endfunction

  task automatic test_random();
    logic [31:0] tgt;
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      bpi.pred_valid = $urandom_range(0, 3) != 0;
      bpi.pred_pc    = rand_pc() | $urandom_range(0, 3);
      bpi.pred_stall = $urandom_range(0, 3) == 0;
      tgt = 32'h2000_0000 | ($urandom_range(0, 3) << 4);
      bpi.upd_valid  = $urandom_range(0, 1);
      bpi.upd_pc     = rand_pc();
      bpi.upd_taken  = $urandom_range(0, 1);
      bpi.upd_target = tgt;
      bpi.upd_pred_taken  = $urandom_range(0, 1);
      bpi.upd_pred_target = $urandom_range(0, 1) ? tgt : $urandom();
      step();
      chk++; if ({bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target} !== {e_rv, e_tk, e_tgt}) begin errs++; $display("FAIL rand_pred cyc%0d: got %0h/%0h/%08h want %0h/%0h/%08h", n, bpi.pred_resp_valid, bpi.pred_taken, bpi.pred_target, e_rv, e_tk, e_tgt); end
      chk++; if ({bpi.redirect_valid, bpi.redirect_pc} !== {e_redv, e_rpc}) begin errs++; $display("FAIL rand_redirect cyc%0d: got %0h/%08h want %0h/%08h", n, bpi.redirect_valid, bpi.redirect_pc, e_redv, e_rpc); end
      chk++; if ({bpi.stat_branches, bpi.stat_mispredicts} !== {e_br, e_mp}) begin errs++; $display("FAIL rand_stats cyc%0d: got %0d/%0d want %0d/%0d", n, bpi.stat_branches, bpi.stat_mispredicts, e_br, e_mp); end
    end
  endtask

  initial begin
    idle();
    resetn = 0;
    test_reset();
    test_basic();
    test_not_taken();
    test_same_cycle();
    test_alias();
    test_stall();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: IDX_W, default 6, index width; table depth is 2**IDX_W entries (64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 pred_valid  input  1  fetch stage requests a prediction for pred_pc.
REQ-005 pred_pc  input  32  fetch PC; bits [1:0] ignored.
REQ-006 pred_stall  input  1  hold the current prediction outputs.
REQ-007 pred_resp_valid  output  1  prediction outputs are valid.
REQ-008 pred_taken  output  1  predicted taken.
REQ-009 pred_target  output  32  predicted next PC: the target if taken, else PC+4.
REQ-010 upd_valid  input  1  a resolved branch from the execute-stage branch judge.
REQ-011 upd_pc, upd_target  input  32 each  resolved branch PC and its computed target.
REQ-012 upd_taken  input  1  resolved outcome.
REQ-013 upd_pred_taken, upd_pred_target  input  1, 32  prediction originally carried with this branch.
REQ-014 redirect_valid  output  1  mispredict; the front end flushes.
REQ-015 redirect_pc  output  32  correct next PC.
REQ-016 stat_branches, stat_mispredicts  output  32 each  performance counters.

Function
REQ-017 Each entry holds: valid, tag = pc[31:IDX_W+2], target[31:0], and a 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-018 Index = pc[IDX_W+1:2].
REQ-019 Hit = entry valid and the stored tag equals the PC tag.
REQ-020 Prediction latency is 1 cycle: pred_valid and !pred_stall at edge N register the response, which is visible after edge N.
- pred_taken = hit and counter[1].
- pred_target = the stored target if pred_taken, else pred_pc+4.
REQ-021 While pred_stall=1, all pred_* outputs hold their value and the table read is suppressed.
REQ-022 pred_valid=0 with pred_stall=0 clears pred_resp_valid at the next edge.
REQ-023 Update applies at the edge where upd_valid=1:
- Hit: the counter saturates up if taken, down if not taken (11 stays 11, 00 stays 00). Target is overwritten only when taken.
- Miss, taken: allocate the entry (overwrite any occupant) with valid=1, new tag, upd_target, counter=10.
- Miss, not taken: no table change.
REQ-024 Mispredict = upd_valid and either (upd_taken != upd_pred_taken) or (upd_taken and upd_target != upd_pred_target).
REQ-025 redirect_valid and redirect_pc are registered with 1-cycle latency. redirect_pc = upd_target if upd_taken, else upd_pc+4. redirect_valid is a single-cycle pulse per mispredict.
REQ-026 When predict and update address the same index in the same cycle, the prediction sees pre-update state (read-before-write, no bypass).
REQ-027 stat_branches increments on each upd_valid. stat_mispredicts increments on each mispredict. Both saturate at 32'hFFFF_FFFF.
REQ-028 PC+4 wraps modulo 2**32 (32'hFFFF_FFFC+4 = 0).

Reset
REQ-029 When resetn=0 at an edge, all outputs and table state reset together, including mid-operation; pending requests and updates in that cycle are discarded:
- All valid bits cleared.
- pred_resp_valid=0, pred_taken=0, pred_target=0.
- redirect_valid=0, redirect_pc=0.
- Both statistics counters = 0.
REQ-030 Target and tag storage need no reset; counters need no reset (an entry is re-initialised on allocation).

Structure
REQ-031 Shared package bp_pkg holds the counter encoding constants (SNT/WNT/WT/ST) and the default IDX_W.
REQ-032 One sub-module, bp_sat_counter: a combinational 2-bit saturating next-state function (inputs cnt, taken; output cnt_next), used by the update path.
REQ-033 Table storage is flop arrays; no memory macro is required.

Verification
REQ-034 Reset, then predict pc=0x1C000000 -> pred_resp_valid=1, pred_taken=0, pred_target=0x1C000004.
REQ-035 Update pc=0x1C000010, taken, target=0x1C000100, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x1C000100; a subsequent predict of 0x1C000010 gives taken, target 0x1C000100.
REQ-036 Three not-taken updates on that entry -> counter 10->01->00->00; prediction not taken with target pc+4; stat_mispredicts counts only actual mismatches.
REQ-037 Same-cycle predict and update to index 4 (counter 01, update taken) -> prediction not taken (old state); the next predict is taken.
REQ-038 Aliasing: a taken update for pc=0x1C000110 (same index as 0x1C000010, different tag) -> the later predict of 0x1C000010 misses and is not taken.
REQ-039 Assert resetn=0 while pred_stall=1 and a redirect is pending -> all outputs zero the next cycle and all prior entries miss.
